// File: rtl/pc_sequencer.sv
// Program-counter sequencer: a FETCH/EXEC/UPDATE loop that selects the next PC
// from a jump, a taken branch or sequential flow, and counts retired updates.
module pc_sequencer #(
  parameter logic [15:0] RESET_VEC = 16'h0000
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        imem_ack,
  input  logic        stall,
  input  logic        jmp,
  input  logic [15:0] jmp_target,
  input  logic        br_taken,
  input  logic [15:0] br_offset,
  output logic [15:0] pc,
  output logic [15:0] pc_next,
  output logic        imem_req,
  output logic        instr_valid,
  output logic [1:0]  state,
  output logic [15:0] retired
);

  // Handshakes: the fetch request (imem_req) stays high for the whole FETCH
  // state and the word is taken on the first rising edge where imem_ack is
  // also high; instr_valid marks EXEC and the datapath holds it there with
  // stall, the instruction completing on the first EXEC edge with stall low.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    EXEC   = 2'd2,
    UPDATE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] tgt_q, tgt_d;
  logic [15:0] retired_q, retired_d;
  logic [15:0] pc_seq;

  // All arithmetic is 16 bits wide, so wrap-around is inherent.
  always_comb begin
    pc_seq = pc_q + 16'd1;
    if (jmp)
      pc_next = jmp_target;
    else if (br_taken)
      pc_next = pc_seq + br_offset;
    else
      pc_next = pc_seq;
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    tgt_d       = tgt_q;
    retired_d   = retired_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) state_d = EXEC;
      end
      EXEC: begin
        instr_valid = 1'b1;
        if (!stall) begin
          tgt_d   = pc_next;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        pc_d      = tgt_q;
        retired_d = retired_q + 16'd1;
        state_d   = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q   <= IDLE;
      pc_q      <= RESET_VEC;
      tgt_q     <= RESET_VEC;
      retired_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      tgt_q     <= tgt_d;
      retired_q <= retired_d;
    end
  end

  assign pc      = pc_q;
  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a table of instructions with expected resulting PCs,
// queued when each EXEC completes and compared when the following FETCH starts.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        clear = 1'b1;
  logic        imem_ack = 1'b0;
  logic        stall = 1'b0;
  logic        jmp = 1'b0;
  logic [15:0] jmp_target = 16'h0;
  logic        br_taken = 1'b0;
  logic [15:0] br_offset = 16'h0;
  logic [15:0] pc, pc_next, retired;
  logic        imem_req, instr_valid;
  logic [1:0]  state;

  pc_sequencer #(.RESET_VEC(16'h0000)) dut (
    .clk(clk), .clear(clear), .imem_ack(imem_ack), .stall(stall),
    .jmp(jmp), .jmp_target(jmp_target), .br_taken(br_taken),
    .br_offset(br_offset), .pc(pc), .pc_next(pc_next), .imem_req(imem_req),
    .instr_valid(instr_valid), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        jmp;
    logic [15:0] tgt;
    logic        br;
    logic [15:0] off;
    int          stall_n;
    int          ack_dly;
    logic [15:0] exp_pc;
  } vec_t;

  vec_t        vecs[12];
  logic [15:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] model_pc;
  logic [15:0] model_ret;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget);
    int n = 0;
    while (state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_state", {14'b0, state}, {14'b0, s});
  endtask

  task automatic randomize_idle_inputs();
    imem_ack   = 1'($urandom_range(0, 1));
    stall      = 1'($urandom_range(0, 1));
    jmp        = 1'($urandom_range(0, 1));
    br_taken   = 1'($urandom_range(0, 1));
    jmp_target = 16'($urandom_range(0, 16'hFFFF));
    br_offset  = 16'($urandom_range(0, 16'hFFFF));
  endtask

  task automatic release_and_check_idle();
    @(posedge clk);
    #1 clear = 1'b0;
    @(negedge clk);
    chk("idle_after_clear", {14'b0, state}, 16'd0);
    @(negedge clk);
    chk("fetch_after_idle", {14'b0, state}, 16'd1);
  endtask

  task automatic pop_and_check();
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 16'd1, 16'd0);
    end else begin
      e = exp_q.pop_front();
      chk("pc_after_update", pc, e);
      model_pc = e;
      model_ret = model_ret + 16'd1;
      chk("retired", retired, model_ret);
    end
  endtask

  task automatic run_instr(input vec_t v);
    int exec_cycles;
    for (int k = 0; k < v.ack_dly; k++) begin
      chk("fetch_hold_state", {14'b0, state}, 16'd1);
      chk("fetch_hold_req", {15'b0, imem_req}, 16'd1);
      imem_ack = 1'b0;
      stall = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    chk("fetch_req", {15'b0, imem_req}, 16'd1);
    imem_ack = 1'b1;
    stall = 1'($urandom_range(0, 1));
    jmp = 1'b0;
    br_taken = 1'b0;
    @(negedge clk);
    imem_ack = 1'($urandom_range(0, 1));
    exec_cycles = 0;
    for (int k = 0; k < v.stall_n; k++) begin
      chk("stall_state", {14'b0, state}, 16'd2);
      chk("stall_valid", {15'b0, instr_valid}, 16'd1);
      chk("stall_pc", pc, model_pc);
      stall = 1'b1;
      jmp = (k == 1);
      jmp_target = 16'h0BAD;
      br_taken = 1'b0;
      exec_cycles++;
      @(negedge clk);
    end
    chk("exec_state", {14'b0, state}, 16'd2);
    chk("exec_valid", {15'b0, instr_valid}, 16'd1);
    chk("exec_no_req", {15'b0, imem_req}, 16'd0);
    exec_cycles++;
    stall = 1'b0;
    jmp = v.jmp;
    jmp_target = v.tgt;
    br_taken = v.br;
    br_offset = v.off;
    #1 chk("pc_next", pc_next, v.exp_pc);
    exp_q.push_back(v.exp_pc);
    if (v.stall_n > 0) chk("exec_cycles", 16'(exec_cycles), 16'(v.stall_n + 1));
    @(negedge clk);
    chk("update_state", {14'b0, state}, 16'd3);
    chk("update_pc_held", pc, model_pc);
    chk("update_no_valid", {15'b0, instr_valid}, 16'd0);
    randomize_idle_inputs();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          jmp   tgt       br    off       stl ack exp_pc
    vecs[0]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 0, 0, 16'h0001};
    vecs[1]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 0, 0, 16'h0002};
    vecs[2]  = '{1'b1, 16'h0005, 1'b0, 16'h0000, 0, 0, 16'h0005};
    vecs[3]  = '{1'b0, 16'h0000, 1'b1, 16'hFFFD, 0, 0, 16'h0003};
    vecs[4]  = '{1'b1, 16'h1234, 1'b1, 16'h0010, 0, 0, 16'h1234};
    vecs[5]  = '{1'b0, 16'h0000, 1'b1, 16'h0010, 0, 0, 16'h1245};
    vecs[6]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 4, 0, 16'h1246};
    vecs[7]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 0, 6, 16'h1247};
    vecs[8]  = '{1'b1, 16'hFFFF, 1'b0, 16'h0000, 0, 0, 16'hFFFF};
    vecs[9]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 0, 0, 16'h0000};
    vecs[10] = '{1'b0, 16'h0000, 1'b1, 16'h7FFF, 2, 1, 16'h8000};
    vecs[11] = '{1'b0, 16'h0000, 1'b1, 16'h8000, 0, 0, 16'h0001};
    model_pc = 16'h0000;
    model_ret = 16'h0000;

    #1;
    chk("reset_pc", pc, 16'h0000);
    chk("reset_state", {14'b0, state}, 16'd0);
    chk("reset_retired", retired, 16'd0);
    chk("reset_req", {15'b0, imem_req}, 16'd0);
    chk("reset_valid", {15'b0, instr_valid}, 16'd0);
    @(posedge clk);
    release_and_check_idle();

    for (int i = 0; i < 12; i++) begin
      wait_state(2'd1, 20);
      if (i > 0) pop_and_check();
      run_instr(vecs[i]);
    end
    wait_state(2'd1, 20);
    pop_and_check();
    chk("retired_total", retired, 16'd12);

    // Clear in the middle of EXEC must take effect without a clock edge.
    imem_ack = 1'b1;
    stall = 1'b1;
    @(negedge clk);
    chk("pre_clear_exec", {14'b0, state}, 16'd2);
    #2 clear = 1'b1;
    #1;
    chk("async_clear_pc", pc, 16'h0000);
    chk("async_clear_state", {14'b0, state}, 16'd0);
    chk("async_clear_retired", retired, 16'd0);
    chk("async_clear_valid", {15'b0, instr_valid}, 16'd0);
    chk("async_clear_req", {15'b0, imem_req}, 16'd0);
    imem_ack = 1'b0;
    stall = 1'b0;
    release_and_check_idle();
    chk("fetch_pc_after_clear", pc, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
